spi_regaccess_ctrl: RTL and testbench

Parametrised SPI master for accelerometer register access. Successor to the single-register read controller: bit/byte counters are internal, SCLK divider is configurable, single-byte and burst reads and writes are both supported. Sits between the system FSM and the sensor pins. Drives nCS/sclk/mosi, samples miso, and hands bytes over through a valid/request interface.

---
 rtl/spi_regaccess_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_spi_regaccess_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regaccess_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : spi_regaccess_ctrl
// Brief   : SPI mode-0 master for single/burst accelerometer register access.
// Revision: 1.0
// ============================================================================
module spi_regaccess_ctrl #(
  parameter int         CLK_DIV   = 5,
  parameter int         MAX_BYTES = 8,
  parameter logic [7:0] INSTR_RD  = 8'h0B,
  parameter logic [7:0] INSTR_WR  = 8'h0A,
  parameter int         LEN_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [7:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wdata,
  output logic             wdata_req,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             nCS,
  output logic             mosi,
  input  logic             miso
);

  localparam int                 c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int                 c_byte_w   = LEN_W + 2;
  localparam logic [LEN_W:0]     c_max_len  = (LEN_W + 1)'(MAX_BYTES - 1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_div_w-1:0]  r_div;
  logic                r_phase;
  logic [2:0]          r_bit;
  logic [c_byte_w-1:0] r_byte;
  logic [c_byte_w-1:0] r_last;
  logic                r_rw;
  logic [7:0]          r_addr;
  logic [7:0]          r_wbuf;
  logic [7:0]          r_tx;
  logic [7:0]          r_rx;
  logic                r_rx_done;
  logic [LEN_W-1:0]    w_len_eff;
  logic                w_div_end;
  logic                w_rise;
  logic                w_fall;
  logic                w_data_byte;
  logic                w_last_byte;

  assign w_div_end   = (r_div == c_div_last);
  assign w_rise      = (r_state == S_SHIFT) && !r_phase && w_div_end;
  assign w_fall      = (r_state == S_SHIFT) &&  r_phase && w_div_end;
  assign w_data_byte = (r_byte >= c_byte_w'(2));
  assign w_last_byte = (r_byte == r_last);

  always_comb begin
    w_len_eff = len;
    if ({1'b0, len} > c_max_len) w_len_eff = c_max_len[LEN_W-1:0];
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    nCS       = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    done      = 1'b0;
    wdata_req = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_SETUP;
      end
      S_SETUP: begin
        nCS  = 1'b0;
        mosi = r_tx[7];
        if (w_div_end) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        nCS  = 1'b0;
        sclk = r_phase;
        mosi = r_tx[7];
        // First cycle of bit 7 of a non-final write data byte
        wdata_req = r_rw && !r_phase && (r_div == '0) && (r_bit == 3'd7)
                    && w_data_byte && !w_last_byte;
        if (w_fall && (r_bit == 3'd7) && w_last_byte) w_next = S_HOLD;
      end
      S_HOLD: begin
        nCS = 1'b0;
        if (w_div_end) w_next = S_GAP;
      end
      S_GAP: begin
        done = w_div_end;
        if (w_div_end) w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_div       <= '0;
      r_phase     <= 1'b0;
      r_bit       <= 3'd0;
      r_byte      <= '0;
      r_last      <= '0;
      r_rw        <= 1'b0;
      r_addr      <= 8'h00;
      r_wbuf      <= 8'h00;
      r_tx        <= 8'h00;
      r_rx        <= 8'h00;
      r_rx_done   <= 1'b0;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
    end else begin
      r_rx_done   <= 1'b0;
      rdata_valid <= r_rx_done;
      if (r_rx_done) rdata <= r_rx;
      if (r_state == S_IDLE) begin
        r_div <= '0;
        if (start) begin
          r_rw    <= rw;
          r_addr  <= addr;
          r_wbuf  <= wdata;
          r_last  <= c_byte_w'(w_len_eff) + c_byte_w'(2);
          r_tx    <= rw ? INSTR_WR : INSTR_RD;
          r_phase <= 1'b0;
          r_bit   <= 3'd0;
          r_byte  <= '0;
        end
      end else begin
        r_div <= w_div_end ? '0 : r_div + 1'b1;
        if (w_rise) begin
          r_phase <= 1'b1;
          r_rx    <= {r_rx[6:0], miso};
          if ((r_bit == 3'd7) && w_data_byte && !r_rw) r_rx_done <= 1'b1;
        end
        if (w_fall) begin
          r_phase <= 1'b0;
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            r_byte <= r_byte + 1'b1;
            // Byte boundary: instruction -> addr -> latched byte 0 -> live wdata
            if (r_byte == '0)               r_tx <= r_addr;
            else if (!r_rw)                 r_tx <= 8'h00;
            else if (r_byte == c_byte_w'(1)) r_tx <= r_wbuf;
            else                            r_tx <= wdata;
          end else begin
            r_tx <= {r_tx[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_regaccess_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for spi_regaccess_ctrl: three instances (CLK_DIV 2, default, MAX_BYTES 4)
// share one SPI slave model and a byte-level scoreboard.
module tb_spi_regaccess_ctrl;

  typedef struct {
    int              sel;
    logic            rw;
    logic [7:0]      addr;
    logic [2:0]      len;
    logic [7:0][7:0] d;
    int              bits;
    int              busy;
    int              wreq;
    int              rv;
  } vec_t;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic       rst, start, rw, miso;
  logic [7:0] addr, wdata;
  logic [2:0] len;
  logic [1:0] sel;
  logic [2:0] start_v, sclk_v, ncs_v, mosi_v, busy_v, done_v, wreq_v, rv_v;
  logic [7:0] rdata_v [3];
  logic       sclk_m, ncs_m, mosi_m, busy_m, done_m, wreq_m, rv_m;
  logic [7:0] rdata_m;

  assign start_v[0] = start && (sel == 2'd0);
  assign start_v[1] = start && (sel == 2'd1);
  assign start_v[2] = start && (sel == 2'd2);

  always_comb begin
    sclk_m  = sclk_v[sel];
    ncs_m   = ncs_v[sel];
    mosi_m  = mosi_v[sel];
    busy_m  = busy_v[sel];
    done_m  = done_v[sel];
    wreq_m  = wreq_v[sel];
    rv_m    = rv_v[sel];
    rdata_m = rdata_v[sel];
  end

  spi_regaccess_ctrl #(.CLK_DIV(2), .MAX_BYTES(8)) dut_a (
    .ck(ck), .rst(rst), .start(start_v[0]), .rw(rw), .addr(addr), .len(len),
    .wdata(wdata), .wdata_req(wreq_v[0]), .rdata(rdata_v[0]), .rdata_valid(rv_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sclk(sclk_v[0]), .nCS(ncs_v[0]),
    .mosi(mosi_v[0]), .miso(miso));

  spi_regaccess_ctrl dut_b (
    .ck(ck), .rst(rst), .start(start_v[1]), .rw(rw), .addr(addr), .len(len),
    .wdata(wdata), .wdata_req(wreq_v[1]), .rdata(rdata_v[1]), .rdata_valid(rv_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sclk(sclk_v[1]), .nCS(ncs_v[1]),
    .mosi(mosi_v[1]), .miso(miso));

  spi_regaccess_ctrl #(.CLK_DIV(2), .MAX_BYTES(4), .LEN_W(3)) dut_c (
    .ck(ck), .rst(rst), .start(start_v[2]), .rw(rw), .addr(addr), .len(len),
    .wdata(wdata), .wdata_req(wreq_v[2]), .rdata(rdata_v[2]), .rdata_valid(rv_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sclk(sclk_v[2]), .nCS(ncs_v[2]),
    .mosi(mosi_v[2]), .miso(miso));

  int         n_vec = 0;
  int         n_bad = 0;
  int         cdiv;
  logic [7:0] emq[$];
  logic [7:0] erq[$];
  logic [7:0] sq[$];
  logic [7:0] wq[$];
  int         rises, ncs_low, busy_cnt, done_cnt, wreq_cnt, rv_cnt, sclk_bad;
  int         frame_rises, run, s_idx;
  logic       prev_sclk, prev_ncs;
  logic [7:0] sh, s_cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock of slave model + monitor, evaluated on the falling ck edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge ck);
    if (!ncs_m && prev_ncs) begin
      frame_rises = 0;
      s_idx = 0;
      s_cur = (sq.size() > 0) ? sq.pop_front() : 8'h00;
      miso = s_cur[7];
    end
    if (!ncs_m)  ncs_low++;
    if (busy_m)  busy_cnt++;
    if (done_m)  done_cnt++;
    if (wreq_m) begin
      wreq_cnt++;
      if (wq.size() > 0) wdata = wq.pop_front();
    end
    if (rv_m) begin
      rv_cnt++;
      e = (erq.size() > 0) ? erq.pop_front() : 8'bx;
      chk("rdata", rdata_m, e);
    end
    if (sclk_m && !prev_sclk) begin
      if (frame_rises > 0 && run != cdiv) sclk_bad++;
      run = 1;
      rises++;
      frame_rises++;
      sh = {sh[6:0], mosi_m};
      if (frame_rises % 8 == 0) begin
        e = (emq.size() > 0) ? emq.pop_front() : 8'bx;
        chk("mosi_byte", sh, e);
      end
    end else if (!sclk_m && prev_sclk) begin
      if (run != cdiv) sclk_bad++;
      run = 1;
      s_idx++;
      if (s_idx == 8) begin
        s_idx = 0;
        s_cur = (sq.size() > 0) ? sq.pop_front() : 8'h00;
      end
      miso = s_cur[7 - s_idx];
    end else begin
      run++;
    end
    prev_sclk = sclk_m;
    prev_ncs  = ncs_m;
  endtask

  function automatic vec_t mk(input int s, input logic w, input logic [7:0] a,
                              input logic [2:0] l, input logic [63:0] d,
                              input int b, input int bz, input int wr, input int r);
    vec_t v;
    v.sel = s; v.rw = w; v.addr = a; v.len = l; v.d = d;
    v.bits = b; v.busy = bz; v.wreq = wr; v.rv = r;
    return v;
  endfunction

  task automatic clear_q();
    emq.delete(); erq.delete(); sq.delete(); wq.delete();
  endtask

  task automatic launch(input vec_t v);
    int leff, maxb;
    cdiv = (v.sel == 1) ? 5 : 2;
    maxb = (v.sel == 2) ? 4 : 8;
    leff = (int'(v.len) > maxb - 1) ? maxb - 1 : int'(v.len);
    clear_q();
    emq.push_back(v.rw ? 8'h0A : 8'h0B);
    emq.push_back(v.addr);
    sq.push_back(8'hC3);
    sq.push_back(8'h3C);
    for (int i = 0; i <= leff; i++) begin
      emq.push_back(v.rw ? v.d[i] : 8'h00);
      sq.push_back(v.rw ? 8'h69 : v.d[i]);
      if (!v.rw) erq.push_back(v.d[i]);
      if (v.rw && i > 0) wq.push_back(v.d[i]);
    end
    rises = 0; ncs_low = 0; busy_cnt = 0; done_cnt = 0;
    wreq_cnt = 0; rv_cnt = 0; sclk_bad = 0;
    sel = 2'(v.sel); rw = v.rw; addr = v.addr; len = v.len; wdata = v.d[0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish(input vec_t v, input int glitch_at, input bit early);
    int t;
    bit seen;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 4000) begin
      tick();
      t++;
      if (glitch_at > 0 && t == glitch_at) begin
        start = 1'b1; rw = ~rw; addr = 8'h99; len = 3'd3;
      end else if (glitch_at > 0 && t == glitch_at + 1) begin
        start = 1'b0;
      end
      if (done_m) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    if (!seen) return;
    chk("done_in_gap", {busy_m, ncs_m}, 2'b11);
    if (early) start = 1'b1;
    tick();
    if (early) chk("start_on_done_ignored", busy_m, 0);
    chk("busy_cycles", busy_cnt, v.busy);
    chk("ncs_low_cycles", ncs_low, v.busy - cdiv);
    chk("sclk_rises", rises, v.bits);
    chk("done_pulses", done_cnt, 1);
    chk("wdata_req_pulses", wreq_cnt, v.wreq);
    chk("rdata_valid_pulses", rv_cnt, v.rv);
    chk("sclk_halfperiod_errs", sclk_bad, 0);
    chk("mosi_bytes_left", emq.size(), 0);
    chk("rdata_left", erq.size(), 0);
  endtask

  initial begin
    vec_t tbl[7];
    vec_t g0, g1, r5w, r5r;
    int   t, dn;
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = 8'h00; len = 3'd0; wdata = 8'h00;
    miso = 1'b0; sel = 2'd0; cdiv = 2; prev_sclk = 1'b0; prev_ncs = 1'b1;
    sh = 8'h00; s_cur = 8'h00; run = 0; s_idx = 0; frame_rises = 0;
    rises = 0; ncs_low = 0; busy_cnt = 0; done_cnt = 0; wreq_cnt = 0; rv_cnt = 0; sclk_bad = 0;

    //            sel rw    addr   len   data (byte0 in [7:0])     bits busy wreq rv
    tbl[0] = mk(0, 1'b0, 8'h00, 3'd0, 64'h00000000_000000AD, 24, 102, 0, 1);
    tbl[1] = mk(0, 1'b1, 8'h2D, 3'd1, 64'h00000000_00000A02, 32, 134, 1, 0);
    tbl[2] = mk(1, 1'b0, 8'h0E, 3'd5, 64'h00001615_14131211, 64, 655, 0, 6);
    tbl[3] = mk(2, 1'b0, 8'h3A, 3'd7, 64'h88776655_94939291, 48, 198, 0, 4);
    tbl[4] = mk(1, 1'b1, 8'h55, 3'd0, 64'h00000000_000000C7, 24, 255, 0, 0);
    tbl[5] = mk(2, 1'b1, 8'h10, 3'd7, 64'hF8F7F6F5_E4E3E2E1, 48, 198, 3, 0);
    tbl[6] = mk(0, 1'b0, 8'h7F, 3'd3, 64'h00000000_FF00A55A, 48, 198, 0, 4);
    g0  = mk(0, 1'b0, 8'h21, 3'd1, 64'h00000000_0000B2B1, 32, 134, 0, 2);
    g1  = mk(0, 1'b1, 8'h33, 3'd2, 64'h00000000_00030201, 40, 166, 2, 0);
    r5w = mk(0, 1'b1, 8'h44, 3'd2, 64'h00000000_00CCBBAA, 40, 166, 2, 0);
    r5r = mk(0, 1'b0, 8'h0F, 3'd1, 64'h00000000_00004E4D, 32, 134, 0, 2);

    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("reset_pins", {ncs_v[i], sclk_v[i], mosi_v[i], busy_v[i], done_v[i],
                         wreq_v[i], rv_v[i]}, 7'b1000000);
      chk("reset_rdata", rdata_v[i], 8'h00);
    end
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      launch(tbl[i]);
      finish(tbl[i], 0, 1'b0);
    end

    // Stray start mid-SHIFT, start during done, then start right after done
    launch(g0);
    finish(g0, 20, 1'b1);
    launch(g1);
    finish(g1, 0, 1'b0);

    // Reset during data byte 1 of a write, then a clean read
    launch(r5w);
    t = 0;
    while (rises < 28 && t < 4000) begin
      tick();
      t++;
    end
    chk("reached_data_byte1", rises >= 28, 1);
    dn = done_cnt;
    rst = 1'b1;
    #1;
    chk("rst_async_pins", {ncs_v[0], sclk_v[0], busy_v[0], done_v[0]}, 4'b1000);
    clear_q();
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_no_done", done_cnt, dn);
    launch(r5r);
    finish(r5r, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
